// File: rtl/sd_pixel_pkg.sv
// Shared types for the SD byte-stream to RGB888 pixel packer.
package sd_pixel_pkg;

    localparam int unsigned COORD_W = 10;

    typedef struct packed {
        logic [23:0]        rgb;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               sof;
        logic               eol;
    } pixel_t;

    typedef enum logic [1:0] {SKIP, PACK, DONE} state_t;

endpackage

// File: rtl/sd_pixel_packer_sync_fifo.sv
// Synchronous first-word fall-through FIFO; a push while full succeeds only alongside a pop.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        full    = (count == (AW+1)'(DEPTH));
        empty   = (count == '0);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        // Head is masked while empty so idle outputs read as zero.
        dout    = empty ? '0 : mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sd_pixel_packer.sv
// Packs SD file bytes (R,G,B order) into coordinate-tagged pixels behind a small FWFT FIFO.
module sd_pixel_packer
    import sd_pixel_pkg::*;
#(
    parameter int unsigned HEADER_BYTES = 0,
    parameter int unsigned FRAME_WIDTH  = 640,
    parameter int unsigned FRAME_HEIGHT = 480,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        restart,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] out_rgb,
    output logic [9:0]  out_x,
    output logic [9:0]  out_y,
    output logic        out_sof,
    output logic        out_eol,
    output logic        frame_done,
    output logic        overflow
);
    localparam state_t             START    = (HEADER_BYTES == 0) ? PACK : SKIP;
    localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(FRAME_WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(FRAME_HEIGHT - 1);
    localparam logic [31:0]        HDR_LAST = 32'((HEADER_BYTES == 0) ? 0 : HEADER_BYTES - 1);

    state_t             state;
    state_t             state_next;
    logic [1:0]         phase;
    logic [7:0]         r_byte;
    logic [7:0]         g_byte;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [31:0]        skip_cnt;
    logic               accept;
    logic               complete;
    logic               last_pix;
    logic               fifo_full;
    logic               fifo_empty;
    pixel_t             push_pix;
    pixel_t             head_pix;

    always_comb begin
        accept   = in_valid && !restart;
        complete = accept && (state == PACK) && (phase == 2'd2);
        last_pix = (x == X_LAST) && (y == Y_LAST);
        push_pix = '{rgb: {r_byte, g_byte, in_byte}, x: x, y: y,
                     sof: (x == '0) && (y == '0), eol: (x == X_LAST)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= START;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (restart)
            state_next = START;
        else begin
            case (state)
                SKIP:    if (in_valid && skip_cnt == HDR_LAST) state_next = PACK;
                PACK:    if (complete && last_pix) state_next = DONE;
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase    <= '0;
            r_byte   <= '0;
            g_byte   <= '0;
            x        <= '0;
            y        <= '0;
            skip_cnt <= '0;
            overflow <= 1'b0;
        end else if (restart) begin
            phase    <= '0;
            x        <= '0;
            y        <= '0;
            skip_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (in_valid && state == SKIP)
                skip_cnt <= skip_cnt + 32'd1;
            if (accept && state == PACK) begin
                case (phase)
                    2'd0:    begin r_byte <= in_byte; phase <= 2'd1; end
                    2'd1:    begin g_byte <= in_byte; phase <= 2'd2; end
                    default: phase <= 2'd0;
                endcase
            end
            // Coordinates advance even when the pixel is dropped.
            if (complete) begin
                if (fifo_full && !out_ready)
                    overflow <= 1'b1;
                if (x == X_LAST) begin
                    x <= '0;
                    y <= y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end
        end
    end

    sync_fifo #(
        .WIDTH ($bits(pixel_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (complete),
        .pop   (out_ready),
        .flush (restart),
        .din   (push_pix),
        .dout  (head_pix),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        out_valid  = !fifo_empty;
        out_rgb    = head_pix.rgb;
        out_x      = head_pix.x;
        out_y      = head_pix.y;
        out_sof    = head_pix.sof;
        out_eol    = head_pix.eol;
        frame_done = (state == DONE) && fifo_empty;
    end

endmodule

// File: tb/tb_sd_pixel_packer.sv
// Directed and randomized checks of sd_pixel_packer against a byte-count / queue reference model.
module tb_sd_pixel_packer;
    localparam int HDR   = 2;
    localparam int W     = 8;
    localparam int H     = 2;
    localparam int DEPTH = 4;
    localparam int NPIX  = W * H;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        restart;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_rgb;
    logic [9:0]  out_x;
    logic [9:0]  out_y;
    logic        out_sof;
    logic        out_eol;
    logic        frame_done;
    logic        overflow;

    always #5 clk = ~clk;

    sd_pixel_packer #(
        .HEADER_BYTES (HDR),
        .FRAME_WIDTH  (W),
        .FRAME_HEIGHT (H),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .restart    (restart),
        .in_valid   (in_valid),
        .in_byte    (in_byte),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_rgb    (out_rgb),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_sof    (out_sof),
        .out_eol    (out_eol),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    typedef struct packed {
        logic [23:0] rgb;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        sof;
        logic        eol;
    } exp_t;

    exp_t        q[$];
    int unsigned bcount;
    int unsigned pcount;
    int unsigned transfers = 0;
    logic        m_ovf;
    logic [7:0]  m_r;
    logic [7:0]  m_g;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        q.delete();
        bcount = 0;
        pcount = 0;
        m_ovf  = 1'b0;
    endtask

    // Reference: header bytes are skipped, then every third byte closes pixel number pcount.
    task automatic model_edge(input logic v, input logic [7:0] b, input logic rdy, input logic rs);
        exp_t p;
        int unsigned lane;
        if (rs) begin
            model_clear();
            return;
        end
        if (rdy && q.size() > 0) begin
            void'(q.pop_front());
            transfers++;
        end
        if (v && pcount < NPIX) begin
            if (bcount < HDR) begin
                bcount++;
            end else begin
                lane = (bcount - HDR) % 3;
                if (lane == 0) m_r = b;
                else if (lane == 1) m_g = b;
                else begin
                    p.rgb = {m_r, m_g, b};
                    p.x   = 10'(pcount % W);
                    p.y   = 10'(pcount / W);
                    p.sof = (pcount == 0);
                    p.eol = ((pcount % W) == W - 1);
                    if (q.size() < DEPTH) q.push_back(p);
                    else m_ovf = 1'b1;
                    pcount++;
                end
                bcount++;
            end
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", out_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk("out_rgb", out_rgb, q[0].rgb);
            chk("out_x", out_x, q[0].x);
            chk("out_y", out_y, q[0].y);
            chk("out_sof", out_sof, q[0].sof);
            chk("out_eol", out_eol, q[0].eol);
        end
        chk("overflow", overflow, m_ovf);
        chk("frame_done", frame_done, (pcount == NPIX) && (q.size() == 0));
    endtask

    task automatic step(input logic v, input logic [7:0] b, input logic rdy, input logic rs);
        in_valid  = v;
        in_byte   = b;
        out_ready = rdy;
        restart   = rs;
        @(posedge clk);
        model_edge(v, b, rdy, rs);
        #1;
        check_outputs();
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() > 0; i++)
            step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("drain_bound", out_valid, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_valid"}, out_valid, 1'b0);
        chk({tag, "_rgb"}, out_rgb, 24'h0);
        chk({tag, "_x"}, out_x, 10'd0);
        chk({tag, "_y"}, out_y, 10'd0);
        chk({tag, "_sof"}, out_sof, 1'b0);
        chk({tag, "_eol"}, out_eol, 1'b0);
        chk({tag, "_done"}, frame_done, 1'b0);
        chk({tag, "_ovf"}, overflow, 1'b0);
    endtask

    initial begin
        logic [7:0] hdr_seq [8];
        logic [7:0] b;
        logic [7:0] rb, gb, bb;
        int unsigned t0;

        rst_n = 1'b0; restart = 1'b0; in_valid = 1'b0; in_byte = '0; out_ready = 1'b0;
        model_clear();
        #2;
        check_reset_values("reset");
        #10;
        rst_n = 1'b1;

        // Header skip and first two pixels.
        hdr_seq = '{8'hAA, 8'hBB, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        for (int i = 0; i < 8; i++) begin
            step(1'b1, hdr_seq[i], 1'b1, 1'b0);
            if (i == 4) begin
                chk("px0_rgb", out_rgb, 24'h112233);
                chk("px0_sof", out_sof, 1'b1);
            end
        end
        chk("px1_rgb", out_rgb, 24'h445566);
        chk("px1_x", out_x, 10'd1);

        // Rest of the frame, line wrap, DONE behaviour.
        for (int i = 0; i < 3 * (NPIX - 2); i++)
            step(1'b1, 8'($urandom), 1'b1, 1'b0);
        drain();
        chk("frame_done_set", frame_done, 1'b1);
        step(1'b1, 8'($urandom), 1'b1, 1'b0);
        chk("done_byte_valid", out_valid, 1'b0);
        chk("done_byte_done", frame_done, 1'b1);

        // Backpressure and overflow.
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < HDR + 18; i++)
            step(1'b1, 8'($urandom), 1'b0, 1'b0);
        chk("ovf_set", overflow, 1'b1);
        for (int i = 0; i < DEPTH; i++)
            step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b1, 8'($urandom), 1'b1, 1'b0);
        chk("ovf_next_x", out_x, 10'd6);
        chk("ovf_next_y", out_y, 10'd0);

        // Restart one byte into a pixel, with a byte in the same cycle.
        step(1'b1, 8'h5A, 1'b1, 1'b0);
        step(1'b1, 8'hC3, 1'b1, 1'b1);
        chk("rst_fifo_empty", out_valid, 1'b0);
        chk("rst_ovf_clear", overflow, 1'b0);
        rb = 8'($urandom); gb = 8'($urandom); bb = 8'($urandom);
        step(1'b1, 8'hEE, 1'b1, 1'b0);
        step(1'b1, 8'hEF, 1'b1, 1'b0);
        step(1'b1, rb, 1'b1, 1'b0);
        step(1'b1, gb, 1'b1, 1'b0);
        step(1'b1, bb, 0, 1'b0);
        chk("rst_px_sof", out_sof, 1'b1);
        chk("rst_px_rgb", out_rgb, {rb, gb, bb});

        // Randomized stalls across a whole frame without overflow.
        step(1'b0, 8'h00, 1'b0, 1'b1);
        t0 = transfers;
        for (int i = 0; i < 3000 && pcount < NPIX; i++) begin
            b = 8'($urandom);
            step(($urandom_range(0, 1) == 1) && (q.size() < DEPTH), b,
                 $urandom_range(0, 1) == 1, 1'b0);
        end
        drain();
        chk("stall_transfers", transfers - t0, NPIX);
        chk("stall_done", frame_done, 1'b1);

        // Asynchronous reset while a pixel is waiting.
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < HDR + 3; i++)
            step(1'b1, 8'($urandom), 1'b0, 1'b0);
        chk("pre_areset_valid", out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("areset");
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < HDR + 3; i++)
            step(1'b1, 8'($urandom), 1'b1, 1'b0);
        chk("post_areset_sof", out_sof, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
